// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO drain-side stream reader.
package fifo_pkg;

    localparam int DATA_SIZE_DEF = 32;

    // Pointer width for an N-entry circular buffer; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    typedef struct packed {
        logic                     valid;
        logic [DATA_SIZE_DEF-1:0] data;
    } beat_t;

endpackage

// File: rtl/fifo_stream_skid_buf.sv
// Circular output buffer with push/pop/occupancy; reads 0 on m_data while empty.
module fifo_stream_skid_buf
    import fifo_pkg::*;
#(
    parameter  int data_size = DATA_SIZE_DEF,
    parameter  int out_depth = 3,
    localparam int PTR_W     = ptr_width(out_depth),
    localparam int OCC_W     = $clog2(out_depth + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_i,
    input  logic [data_size-1:0] push_data_i,
    input  logic                 pop_i,
    output logic                 valid_o,
    output logic [data_size-1:0] data_o,
    output logic [OCC_W-1:0]     occ_o
);

    logic [data_size-1:0] mem_q [out_depth];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic                 pop_ok;

    // Explicit compare keeps non-power-of-2 depths wrapping correctly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(out_depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok = pop_i && (occ_q != '0);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (push_i) begin
            tail_d = ptr_inc(tail_q);
        end
        if (pop_ok) begin
            head_d = ptr_inc(head_q);
        end
        case ({push_i, pop_ok})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    assign valid_o = (occ_q != '0);
    assign data_o  = valid_o ? mem_q[head_q] : '0;
    assign occ_o   = occ_q;

    // The issue rule reserves a slot for every read, so a full-buffer capture is a design bug.
    assert property (@(posedge clk) disable iff (!reset) push_i |-> (occ_q != OCC_W'(out_depth)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Reader end of synch_fifo: issues reads, captures one cycle later, streams out valid/ready.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int data_size = DATA_SIZE_DEF,
    parameter int out_depth = 3,
    parameter int cnt_width = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [data_size-1:0] fifo_data,
    output logic                 fifo_cs,
    output logic                 fifo_rd_en,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [data_size-1:0] m_data,
    output logic [cnt_width-1:0] rd_count,
    output logic                 busy
);

    localparam int OCC_W = $clog2(out_depth + 1);

    logic                 armed_q;
    logic                 pending_q, pending_d;
    logic [cnt_width-1:0] cnt_q, cnt_d;
    logic [OCC_W-1:0]     occ;
    logic                 room;
    logic                 pop;

    // Count the in-flight read against capacity so its capture always has a slot.
    assign room = ({1'b0, occ} + {{OCC_W{1'b0}}, pending_q}) < (OCC_W + 1)'(out_depth);

    // armed_q holds reads off until the first edge after reset release.
    assign fifo_rd_en = armed_q && enable && !fifo_empty && room;
    assign fifo_cs    = fifo_rd_en;
    assign pending_d  = fifo_rd_en;

    assign pop   = m_valid && m_ready;
    assign cnt_d = pop ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed_q   <= 1'b0;
            pending_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            armed_q   <= 1'b1;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    fifo_stream_skid_buf #(
        .data_size (data_size),
        .out_depth (out_depth)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (pending_q),
        .push_data_i (fifo_data),
        .pop_i       (pop),
        .valid_o     (m_valid),
        .data_o      (m_data),
        .occ_o       (occ)
    );

    assign rd_count = cnt_q;
    assign busy     = pending_q || m_valid;

endmodule
